pwm_capture: RTL and testbench

- Measures an incoming PWM waveform and reports its high time and period in CLOCK50 cycles.
- It is the receive-side counterpart of the PWM generator. It is used to close the loop on motor drive signals and to read PWM-encoded sensor outputs on the line follower.
- Input is asynchronous to CLOCK50 and is synchronised internally.
- Each result is presented with a one-cycle valid strobe. A stuck-input timeout guarantees that results keep updating.

---
 rtl/pwm_capture.sv | 120 ++++++++++++
 tb/tb_pwm_capture.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: synchronises an asynchronous PWM line and measures high time and
// period in clock cycles, with a timeout so results keep updating on a stuck line.
module pwm_capture #(
   parameter int CNT_W   = 20,
   parameter int TIMEOUT = 1000000
) (
   input  logic             CLOCK50,
   input  logic             reset,
   input  logic             PWM_in,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             stuck,
   output logic [17:0]      LED
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
   logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;

   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt_p_n;
   logic [CNT_W-1:0] cnt_h_n;

   assign rise = s2_q & ~prev_q;
   assign fall = ~s2_q & prev_q;

   always_comb begin
      s1_d        = PWM_in;
      s2_d        = s1_q;
      prev_d      = s2_q;
      state_d     = state_q;
      high_time_d = high_time_q;
      period_d    = period_q;
      valid_d     = 1'b0;
      stuck_d     = stuck_q;
      cnt_p_n     = cnt_p_q + ONE_C;
      cnt_h_n     = cnt_h_q + {{(CNT_W-1){1'b0}}, s2_q};
      cnt_p_d     = cnt_p_n;
      cnt_h_d     = cnt_h_n;

      if (rise) begin
         // The rise cycle itself is the first clock of the new period (and of its high time).
         if (state_q == ST_LOW) begin
            high_time_d = cnt_h_q;
            period_d    = cnt_p_q;
            valid_d     = 1'b1;
            stuck_d     = 1'b0;
         end
         cnt_p_d = ONE_C;
         cnt_h_d = ONE_C;
         state_d = ST_HIGH;
      end else if (cnt_p_n == TIMEOUT_C) begin
         high_time_d = cnt_h_n;
         period_d    = TIMEOUT_C;
         valid_d     = 1'b1;
         stuck_d     = 1'b1;
         cnt_p_d     = '0;
         cnt_h_d     = '0;
         state_d     = ST_IDLE;
      end else if ((state_q == ST_HIGH) && fall) begin
         state_d = ST_LOW;
      end
   end

   always_ff @(posedge CLOCK50) begin
      if (reset) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         prev_q      <= 1'b0;
         cnt_p_q     <= '0;
         cnt_h_q     <= '0;
         state_q     <= ST_IDLE;
         high_time_q <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         prev_q      <= prev_d;
         cnt_p_q     <= cnt_p_d;
         cnt_h_q     <= cnt_h_d;
         state_q     <= state_d;
         high_time_q <= high_time_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         stuck_q     <= stuck_d;
      end
   end

   assign high_time = high_time_q;
   assign period    = period_q;
   assign valid     = valid_q;
   assign stuck     = stuck_q;

   generate
      if (CNT_W > 18) begin : g_led_sat
         assign LED = (|high_time_q[CNT_W-1:18]) ? '1 : high_time_q[17:0];
      end else begin : g_led_ext
         assign LED = 18'(high_time_q);
      end
   endgenerate

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture: a timestamp-based reference model predicts each
// result strobe and a negedge monitor compares the DUT against the prediction queue.
module tb_pwm_capture;

   localparam int CNT_W   = 20;
   localparam int TIMEOUT = 1000;

   logic             clk = 1'b0;
   logic             rst;
   logic             pwm_in;
   logic [CNT_W-1:0] high_time;
   logic [CNT_W-1:0] period;
   logic             valid;
   logic             stuck;
   logic [17:0]      led;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .CLOCK50  (clk),
      .reset    (rst),
      .PWM_in   (pwm_in),
      .high_time(high_time),
      .period   (period),
      .valid    (valid),
      .stuck    (stuck),
      .LED      (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int hi;
      int per;
      bit stk;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   seen_rst = 0;
   int   m_hi = 0;
   int   m_per = 0;
   bit   m_stk = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int led_of(input int h);
      return (h > 262143) ? 262143 : h;
   endfunction

   // Reference model: time is tracked as an origin timestamp rather than counters.
   initial begin
      bit hist[3];
      int origin;
      int hacc;
      bit armed;
      bit eff, pv;
      origin = 0; hacc = 0; armed = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst === 1'b1) begin
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
            origin = cyc; hacc = 0; armed = 0;
            m_hi = 0; m_per = 0; m_stk = 0;
            seen_rst = 1;
         end else if (seen_rst) begin
            eff = hist[1];
            pv  = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = pwm_in;
            if (eff && !pv) begin
               if (armed) begin
                  q.push_back('{cyc, hacc, (cyc - 1) - origin, 1'b0});
                  m_hi = hacc; m_per = (cyc - 1) - origin; m_stk = 0;
               end
               hacc = 1; origin = cyc - 1; armed = 1;
            end else begin
               hacc += int'(eff);
               if (cyc - origin == TIMEOUT) begin
                  q.push_back('{cyc, hacc, TIMEOUT, 1'b1});
                  m_hi = hacc; m_per = TIMEOUT; m_stk = 1;
                  origin = cyc; hacc = 0; armed = 0;
               end
            end
         end
      end
   end

   // Monitor: strobe timing and payload against the queue, held outputs every cycle.
   initial begin
      bit exp_v;
      forever begin
         @(negedge clk);
         if (seen_rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               chk("missed_valid", 0, 1);
               void'(q.pop_front());
            end
            exp_v = (q.size() > 0) && (q[0].cyc == cyc);
            chk("valid", int'(valid), int'(exp_v));
            if (exp_v) begin
               if (valid) begin
                  $display("RESULT cycle %0d high_time %0d period %0d stuck %0d (exp %0d/%0d/%0d)",
                           cyc, high_time, period, stuck, q[0].hi, q[0].per, q[0].stk);
                  chk("strobe_high_time", int'(high_time), q[0].hi);
                  chk("strobe_period", int'(period), q[0].per);
                  chk("strobe_stuck", int'(stuck), int'(q[0].stk));
               end
               void'(q.pop_front());
            end
            chk("hold_high_time", int'(high_time), m_hi);
            chk("hold_period", int'(period), m_per);
            chk("hold_stuck", int'(stuck), int'(m_stk));
            chk("led", int'(led), led_of(m_hi));
         end
      end
   end

   task automatic hold(input bit v, input int n);
      pwm_in = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pwm(input int h, input int l, input int reps);
      for (int i = 0; i < reps; i++) begin
         hold(1'b1, h);
         hold(1'b0, l);
      end
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      chk({tag, "_high_time"}, int'(high_time), 0);
      chk({tag, "_period"}, int'(period), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_stuck"}, int'(stuck), 0);
      chk({tag, "_led"}, int'(led), 0);
   endtask

   initial begin
      pwm_in = 1'b0;
      rst    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_zero("reset");

      hold(1'b0, 2100);            // two timeouts with a low line
      pwm(25, 75, 6);
      pwm(75, 25, 4);
      hold(1'b1, 2500);            // stuck high
      pwm(25, 75, 6);
      pwm(1, 9, 8);
      for (int i = 0; i < 20; i++)
         pwm($urandom_range(1, 40), $urandom_range(1, 40), 1);

      pwm(25, 75, 3);
      hold(1'b1, 10);
      rst = 1'b1;
      hold(1'b1, 1);
      rst = 1'b0;
      check_zero("midreset");
      hold(1'b1, 14);
      hold(1'b0, 75);
      pwm(25, 75, 4);

      hold(1'b0, 20);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
